pkt_sim_frame_gen: RTL

PKT_SIM_FRAME_GEN -- requirements
Module: pkt_sim_frame_gen

---
 rtl/pkt_sim_pkg.sv | 36 +++
 rtl/pkt_sim_period_timer.sv | 46 ++++
 rtl/pkt_sim_frame_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pkt_sim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_sim_pkg
//  Description : Shared types and constants for the packet simulator frame
//                generator: FSM state encoding, data/counter widths and the
//                layout of a generated data word {pkt_count, word_index}.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_sim_pkg;

    localparam int DATA_W       = 64;
    localparam int CNT_W        = 32;

    // A frame word carries the packet number in the upper half and the
    // word index within the packet in the lower half.
    localparam int WORD_IDX_LSB = 0;
    localparam int PKT_CNT_LSB  = CNT_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] pack_word(
        input logic [CNT_W-1:0] pkt_cnt,
        input logic [CNT_W-1:0] word_idx
    );
        logic [DATA_W-1:0] word;
        word = '0;
        word[PKT_CNT_LSB  +: CNT_W] = pkt_cnt;
        word[WORD_IDX_LSB +: CNT_W] = word_idx;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_sim_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_sim_period_timer
//  Description : Free-running packet-start timer. Counts 0..max(period,1)-1
//                while enabled and flags a start tick whenever the count is 0.
//                Disabling parks the count at 0 so the first tick lands in
//                the first enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_sim_period_timer #(
    parameter int CNT_W = pkt_sim_pkg::CNT_W
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last_count;

    // Next count: wrap at the last value of the period (period 0 acts as 1);
    // the compare is >= so a shrinking period cannot strand the counter.
    always_comb begin
        last_count = (period == '0) ? '0 : period - 1'b1;
        count_d    = '0;
        if (enable && (count_q < last_count)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pkt_sim_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_sim_frame_gen
//  Description : Periodic test-frame generator for the 10GbE TX path. On each
//                start tick it emits payload_len 64-bit words
//                {pkt_count, word_index}, flags the last one with
//                tx_end_of_frame and counts completed packets. Ticks that
//                cannot be served (packet in flight or TX FIFO almost full)
//                set the sticky overrun flag.
//  Config      : define PKT_SIM_TIMESTAMP_EN to replace word 0 of each packet
//                with a 64-bit free-running cycle counter sampled at the tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_sim_frame_gen #(
    parameter int DATA_W = pkt_sim_pkg::DATA_W,
    parameter int CNT_W  = pkt_sim_pkg::CNT_W
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  payload_len,
    input  logic [CNT_W-1:0]  period,
    input  logic              tx_afull,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_end_of_frame,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              overrun
);

    import pkt_sim_pkg::*;

    logic              tick;
    state_e            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_idx_q;
    logic [CNT_W-1:0]  pkt_count_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              tx_eof_q;
    logic              overrun_q;
    logic [DATA_W-1:0] first_word;
    logic              start_ok;
    logic              tick_dropped;

    pkt_sim_period_timer #(
        .CNT_W (CNT_W)
    ) u_period_timer (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .enable   (enable),
        .period   (period),
        .tick     (tick)
    );

`ifdef PKT_SIM_TIMESTAMP_EN
    logic [63:0] timestamp_q;

    // Free-running cycle counter stamped into word 0 of each packet.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            timestamp_q <= '0;
        end else begin
            timestamp_q <= timestamp_q + 64'd1;
        end
    end

    assign first_word = timestamp_q;
`else
    assign first_word = pack_word(pkt_count_q, '0);
`endif

    // A tick starts a packet only from IDLE with room downstream and a
    // non-zero length; a zero length is a quiet no-op, anything else is lost.
    assign start_ok     = tick && (state_q == ST_IDLE) && !tx_afull && (payload_len != '0);
    assign tick_dropped = tick && ((state_q == ST_SEND) || (tx_afull && (payload_len != '0)));

    // Packet FSM with registered outputs: the word for cycle N+1 is built at
    // the edge ending cycle N. word_idx_q holds the index of the next word.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            pkt_count_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_eof_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (tick_dropped) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q    <= ST_SEND;
                        len_q      <= payload_len;
                        word_idx_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                        tx_data_q  <= first_word;
                        tx_valid_q <= 1'b1;
                        tx_eof_q   <= (payload_len == {{(CNT_W-1){1'b0}}, 1'b1});
                    end else begin
                        tx_data_q  <= '0;
                        tx_valid_q <= 1'b0;
                        tx_eof_q   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (tx_eof_q) begin
                        // Last word is on the bus this cycle: close the packet.
                        state_q     <= ST_IDLE;
                        word_idx_q  <= '0;
                        pkt_count_q <= pkt_count_q + 1'b1;
                        tx_data_q   <= '0;
                        tx_valid_q  <= 1'b0;
                        tx_eof_q    <= 1'b0;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        tx_data_q  <= pack_word(pkt_count_q, word_idx_q);
                        tx_valid_q <= 1'b1;
                        tx_eof_q   <= (word_idx_q == (len_q - 1'b1));
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    tx_eof_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign tx_end_of_frame = tx_eof_q;
    assign pkt_count       = pkt_count_q;
    assign overrun         = overrun_q;

endmodule
`default_nettype wire
